ntt_dispatcher: RTL and testbench

Command scheduler between `command_processor` and the two `ntt_engine` cores. It buffers incoming commands in a small FIFO and issues each one to an idle engine, round-robin or by slot affinity. It also honours a barrier opcode that stalls dispatch until both engines are idle. Its presence lets Core 1 receive work instead of sitting idle with `cmd_valid` tied low.

---
 rtl/ntt_dispatcher.sv | 182 ++++++++++++++++++
 tb/tb_ntt_dispatcher.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_dispatcher.sv
// ============================================================================
// Module  : ntt_dispatcher
// Purpose : Buffers commands in a small FIFO and issues each to an idle NTT
//           engine (round-robin, or slot affinity when
//           DISPATCH_SLOT_AFFINITY_EN is defined); honours a barrier opcode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_dispatcher #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  BARRIER_OP = 8'hFE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_opcode,
    input  logic [3:0]                    in_slot,
    input  logic [47:0]                   in_dma_addr,
    output logic                          e0_cmd_valid,
    output logic                          e1_cmd_valid,
    output logic [7:0]                    out_opcode,
    output logic [3:0]                    out_slot,
    output logic [47:0]                   out_dma_addr,
    input  logic                          e0_ready,
    input  logic                          e1_ready,
    output logic                          all_idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    dbg_state
);

    localparam int                  c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_RUN     = 2'b00;
    localparam logic [1:0] c_ST_BARRIER = 2'b01;
    localparam logic [1:0] c_ST_ISSUE   = 2'b10;

    logic [7:0]          r_mem_opcode [FIFO_DEPTH];
    logic [3:0]          r_mem_slot   [FIFO_DEPTH];
    logic [47:0]         r_mem_addr   [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_e0_valid;
    logic                r_e1_valid;
    logic                r_pend0;
    logic                r_pend1;
    logic [7:0]          r_out_opcode;
    logic [3:0]          r_out_slot;
    logic [47:0]         r_out_addr;
`ifndef DISPATCH_SLOT_AFFINITY_EN
    logic                r_last_core;
`endif

    logic                w_push;
    logic                w_pop;
    logic                w_head_valid;
    logic                w_head_barrier;
    logic [7:0]          w_head_opcode;
    logic [3:0]          w_head_slot;
    logic [47:0]         w_head_addr;
    logic                w_elig0;
    logic                w_elig1;
    logic                w_issue0;
    logic                w_issue1;
    logic                w_retire;

    assign in_ready       = (r_count < c_DEPTH);
    assign w_push         = in_valid && in_ready;
    assign w_head_valid   = (r_count != '0);
    assign w_head_opcode  = r_mem_opcode[r_rd_ptr];
    assign w_head_slot    = r_mem_slot[r_rd_ptr];
    assign w_head_addr    = r_mem_addr[r_rd_ptr];
    assign w_head_barrier = (w_head_opcode == BARRIER_OP);

    // An engine is free only once its previous command has been seen to drop ready
    assign w_elig0 = e0_ready && !r_pend0 && !r_e0_valid;
    assign w_elig1 = e1_ready && !r_pend1 && !r_e1_valid;

    always_comb begin
        w_issue0    = 1'b0;
        w_issue1    = 1'b0;
        w_retire    = 1'b0;
        w_state_nxt = r_state;
        if (r_state == c_ST_BARRIER) begin
            w_retire    = w_head_valid && w_elig0 && w_elig1;
            w_state_nxt = w_retire ? c_ST_RUN : c_ST_BARRIER;
        end else if (w_head_valid && w_head_barrier) begin
            w_state_nxt = c_ST_BARRIER;
        end else begin
            if (w_head_valid) begin
`ifdef DISPATCH_SLOT_AFFINITY_EN
                w_issue0 = !w_head_slot[3] && w_elig0;
                w_issue1 =  w_head_slot[3] && w_elig1;
`else
                if (w_elig0 && w_elig1) begin
                    w_issue0 =  r_last_core;
                    w_issue1 = !r_last_core;
                end else begin
                    w_issue0 = w_elig0;
                    w_issue1 = w_elig1;
                end
`endif
            end
            w_state_nxt = (w_issue0 || w_issue1) ? c_ST_ISSUE : c_ST_RUN;
        end
    end

    assign w_pop = w_issue0 || w_issue1 || w_retire;

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_opcode[r_wr_ptr] <= in_opcode;
            r_mem_slot[r_wr_ptr]   <= in_slot;
            r_mem_addr[r_wr_ptr]   <= in_dma_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= c_ST_RUN;
            r_e0_valid   <= 1'b0;
            r_e1_valid   <= 1'b0;
            r_pend0      <= 1'b0;
            r_pend1      <= 1'b0;
            r_out_opcode <= '0;
            r_out_slot   <= '0;
            r_out_addr   <= '0;
`ifndef DISPATCH_SLOT_AFFINITY_EN
            r_last_core  <= 1'b1;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_e0_valid <= w_issue0;
            r_e1_valid <= w_issue1;

            if (w_issue0 || w_issue1) begin
                r_out_opcode <= w_head_opcode;
                r_out_slot   <= w_head_slot;
                r_out_addr   <= w_head_addr;
`ifndef DISPATCH_SLOT_AFFINITY_EN
                r_last_core  <= w_issue1;
`endif
            end

            if (w_issue0)      r_pend0 <= 1'b1;
            else if (!e0_ready) r_pend0 <= 1'b0;
            if (w_issue1)      r_pend1 <= 1'b1;
            else if (!e1_ready) r_pend1 <= 1'b0;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign e0_cmd_valid = r_e0_valid;
    assign e1_cmd_valid = r_e1_valid;
    assign out_opcode   = r_out_opcode;
    assign out_slot     = r_out_slot;
    assign out_dma_addr = r_out_addr;
    assign fifo_level   = r_count;
    assign dbg_state    = r_state;
    assign all_idle     = (r_count == '0) && !r_e0_valid && !r_e1_valid &&
                          !r_pend0 && !r_pend1 && e0_ready && e1_ready;

endmodule

`default_nettype wire

// File: tb/tb_ntt_dispatcher.sv
// ============================================================================
// Module  : tb_ntt_dispatcher
// Purpose : Scoreboard bench for ntt_dispatcher with behavioural engine models.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntt_dispatcher;

    localparam logic [7:0] c_BAR = 8'hFE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_opcode = '0;
    logic [3:0]  in_slot = '0;
    logic [47:0] in_dma_addr = '0;
    logic        e0_cmd_valid, e1_cmd_valid;
    logic [7:0]  out_opcode;
    logic [3:0]  out_slot;
    logic [47:0] out_dma_addr;
    logic        e0_ready, e1_ready;
    logic        all_idle;
    logic [2:0]  fifo_level;
    logic [1:0]  dbg_state;

    bit   [1:0]  eng_rdy = 2'b11;
    bit   [1:0]  hold = 2'b00;
    assign e0_ready = eng_rdy[0] & ~hold[0];
    assign e1_ready = eng_rdy[1] & ~hold[1];

    ntt_dispatcher #(.FIFO_DEPTH(4), .BARRIER_OP(c_BAR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_slot(in_slot), .in_dma_addr(in_dma_addr),
        .e0_cmd_valid(e0_cmd_valid), .e1_cmd_valid(e1_cmd_valid),
        .out_opcode(out_opcode), .out_slot(out_slot), .out_dma_addr(out_dma_addr),
        .e0_ready(e0_ready), .e1_ready(e1_ready), .all_idle(all_idle),
        .fifo_level(fifo_level), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  sl;
        logic [47:0] ad;
        int          core;
        int          epoch;
        int          push_cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_mis = 0;
    int   cyc = 0, issued_cnt = 0, cur_epoch = 0;
    bit   rand_mode = 0;
    int   drop_d[2] = '{1, 1};
    int   busy_d[2] = '{5, 5};
    int   ph[2]     = '{0, 0};
    int   cnt[2]    = '{0, 0};
    int   bsy[2]    = '{0, 0};
    int   job_ep[2] = '{0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    // Engine models and output monitor, evaluated just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    ph[k] = 0; cnt[k] = 0; eng_rdy[k] = 1'b1;
                end
            end else begin
                int  core;
                bit  viol;
                exp_t e;
                if (ph[0] != 0 || ph[1] != 0) chk("all_idle_busy", {63'd0, all_idle}, 64'd0);
                if (e0_cmd_valid && e1_cmd_valid) fail_now("dual_issue");
                core = e1_cmd_valid ? 1 : 0;
                if (e0_cmd_valid || e1_cmd_valid) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_issue");
                    end else begin
                        e = sb.pop_front();
                        chk("opcode", {56'd0, out_opcode}, {56'd0, e.op});
                        chk("slot", {60'd0, out_slot}, {60'd0, e.sl});
                        chk("dma_addr", {16'd0, out_dma_addr}, {16'd0, e.ad});
                        chk("dbg_issue", {62'd0, dbg_state}, 64'd2);
                        if (e.core >= 0) chk("core", 64'(core), 64'(e.core));
                        if (e.lat) chk("latency", 64'(cyc), 64'(e.push_cyc + 1));
                        viol = 0;
                        for (int k = 0; k < 2; k++)
                            if (ph[k] != 0 && job_ep[k] < e.epoch) viol = 1;
                        chk("barrier_order", {63'd0, viol}, 64'd0);
                        job_ep[core] = e.epoch;
                    end
                    chk("issue_to_busy", 64'(ph[core]), 64'd0);
                    issued_cnt++;
                end
                for (int k = 0; k < 2; k++) begin
                    if (ph[k] == 1) begin
                        cnt[k]--;
                        if (cnt[k] <= 0) begin eng_rdy[k] = 1'b0; ph[k] = 2; cnt[k] = bsy[k]; end
                    end else if (ph[k] == 2) begin
                        cnt[k]--;
                        if (cnt[k] <= 0) begin eng_rdy[k] = 1'b1; ph[k] = 0; end
                    end
                end
                if (e0_cmd_valid || e1_cmd_valid) begin
                    ph[core]  = 1;
                    cnt[core] = rand_mode ? int'($urandom_range(1, 4)) : drop_d[core];
                    bsy[core] = rand_mode ? int'($urandom_range(1, 8)) : busy_d[core];
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        hold = 2'b00;
        sb.delete();
        cur_epoch = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after the push
    task automatic push(input logic [7:0] op, input logic [3:0] sl,
                        input logic [47:0] ad, input int core, input bit lat);
        int   guard = 0;
        exp_t e;
        in_valid = 1'b1; in_opcode = op; in_slot = sl; in_dma_addr = ad;
        while (!in_ready && guard < 500) begin @(negedge clk); guard++; end
        if (guard >= 500) begin
            fail_now("push_timeout");
            in_valid = 1'b0;
            return;
        end
        if (op == c_BAR) begin
            cur_epoch++;
        end else begin
            e.op = op; e.sl = sl; e.ad = ad; e.core = core;
            e.epoch = cur_epoch; e.push_cyc = cyc + 1; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || ph[0] != 0 || ph[1] != 0) && n < budget) begin
            @(negedge clk); n++;
        end
        if (n >= budget) fail_now("drain_timeout");
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_issue(input int base);
        int n = 0;
        while (issued_cnt == base && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_now("issue_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        @(negedge clk);
        do_reset();

        // Reset values
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_e0_valid", {63'd0, e0_cmd_valid}, 64'd0);
        chk("rst_e1_valid", {63'd0, e1_cmd_valid}, 64'd0);
        chk("rst_out", {out_opcode, out_slot, 4'd0, out_dma_addr}, 64'd0);
        chk("rst_level", {61'd0, fifo_level}, 64'd0);
        chk("rst_dbg", {62'd0, dbg_state}, 64'd0);
        chk("rst_all_idle", {63'd0, all_idle}, 64'd1);

        // Single command: latency and idle return
        drop_d = '{1, 1}; busy_d = '{5, 5};
        push(8'h01, 4'd2, 48'h0000_1234_5678, 0, 1);
        chk("single_not_idle", {63'd0, all_idle}, 64'd0);
        wait_idle(200);
        chk("single_idle", {63'd0, all_idle}, 64'd1);

        // Round-robin order 0,1,0,1
        do_reset();
        drop_d = '{1, 1}; busy_d = '{20, 20};
        push(8'h10, 4'd0, 48'hA0, 0, 0);
        push(8'h11, 4'd8, 48'hA1, 1, 0);
        push(8'h12, 4'd0, 48'hA2, 0, 0);
        push(8'h13, 4'd8, 48'hA3, 1, 0);
        wait_idle(400);

        // Full FIFO with both engines held busy
        do_reset();
        drop_d = '{1, 1}; busy_d = '{3, 3};
        hold = 2'b11;
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 4'(i), 48'(i * 16), -1, 0);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_level", {61'd0, fifo_level}, 64'd4);
        base = issued_cnt;
        fork
            begin repeat (10) @(negedge clk); hold = 2'b00; end
            push(8'h24, 4'd4, 48'h40, -1, 0);
        join
        chk("full_fifth_after_issue", {63'd0, (issued_cnt > base)}, 64'd1);
        wait_idle(400);

        // Barrier: B must wait for both engines
        do_reset();
        drop_d = '{1, 1}; busy_d = '{30, 5};
        push(8'h30, 4'd0, 48'hB0, 0, 0);
        push(c_BAR, 4'd0, 48'h0, -1, 0);
        push(8'h31, 4'd8, 48'hB1, 1, 0);
        repeat (8) @(negedge clk);
        chk("barrier_dbg", {62'd0, dbg_state}, 64'd1);
        chk("barrier_hold", 64'(sb.size()), 64'd1);
        wait_idle(400);

`ifdef DISPATCH_SLOT_AFFINITY_EN
        // Affinity: both slot[3]=1 commands wait for core 1
        do_reset();
        drop_d = '{1, 1}; busy_d = '{5, 5};
        hold = 2'b10;
        base = issued_cnt;
        push(8'h40, 4'd8, 48'hC0, 1, 0);
        push(8'h41, 4'd9, 48'hC1, 1, 0);
        repeat (10) @(negedge clk);
        chk("aff_wait", 64'(issued_cnt - base), 64'd0);
        hold = 2'b00;
        wait_idle(400);
`endif

        // Reset mid-operation
        do_reset();
        drop_d = '{1, 1}; busy_d = '{60, 60};
        hold = 2'b10;
        base = issued_cnt;
        push(8'h50, 4'd0, 48'hD0, 0, 0);
        wait_issue(base);
        for (int i = 0; i < 3; i++) push(8'h51 + 8'(i), 4'd1, 48'hD1, -1, 0);
        chk("mid_level_before", {61'd0, fifo_level}, 64'd3);
        do_reset();
        chk("mid_level_after", {61'd0, fifo_level}, 64'd0);
        base = issued_cnt;
        repeat (5) @(negedge clk);
        chk("mid_quiet", 64'(issued_cnt - base), 64'd0);
        busy_d = '{5, 5};
        push(8'h60, 4'd0, 48'hE0, 0, 0);
        wait_idle(200);

        // Randomized traffic with occasional barriers
        do_reset();
        rand_mode = 1;
        for (int i = 0; i < 150; i++) begin
            logic [7:0]  op;
            logic [3:0]  sl;
            logic [63:0] ad;
            int          core;
            op = ($urandom_range(0, 9) == 0) ? c_BAR : 8'($urandom_range(0, 253));
            sl = 4'($urandom_range(0, 15));
            ad = {$urandom, $urandom};
`ifdef DISPATCH_SLOT_AFFINITY_EN
            core = int'(sl[3]);
`else
            core = -1;
`endif
            push(op, sl, ad[47:0], core, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(3000);
        chk("rand_level", {61'd0, fifo_level}, 64'd0);
        chk("rand_all_idle", {63'd0, all_idle}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
